// File: rtl/sdf_1p_2f_ms_wrap_pkg.sv
// Shared constants for the multi-stream SDF accumulator wrapper.
// Tokens are {tag, data} with the stream tag in the MSBs.
package sdf_1p_2f_ms_wrap_pkg;
    localparam int unsigned FLUX       = 2;
    localparam int unsigned TAG_WIDTH  = $clog2(FLUX);
    localparam int unsigned WIDTH      = 9;
    localparam int unsigned DATA_WIDTH = WIDTH - TAG_WIDTH;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam int unsigned TAG_MSB  = WIDTH - 1;
    localparam int unsigned TAG_LSB  = DATA_WIDTH;
    localparam int unsigned DATA_MSB = DATA_WIDTH - 1;
endpackage

// File: rtl/sdf_ms_fifo.sv
// Per-stream synchronous FIFO. The head entry is visible on dout whenever not empty.
// full is taken from the registered count, so a push at a full edge is refused even alongside a pop.
module sdf_ms_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sdf_1p_2f_ms_wrap.sv
// Multi-stream wrapper: tag demux into per-stream FIFOs, round-robin pick,
// per-stream running-sum actor and registered tagged output.
module sdf_1p_2f_ms_wrap
    import sdf_1p_2f_ms_wrap_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_port_write,
    input  logic [WIDTH-1:0] in_port_datain,
    output logic [FLUX-1:0]  in_port_full,
    output logic             out_port_write,
    output logic [WIDTH-1:0] out_port_dataout,
    input  logic             out_port_full
);
    logic [TAG_WIDTH-1:0]  in_tag;
    logic [DATA_WIDTH-1:0] in_data;
    logic [FLUX-1:0]       push_sel;
    logic [FLUX-1:0]       pop_sel;
    logic [FLUX-1:0]       fifo_empty;
    logic [DATA_WIDTH-1:0] head [FLUX];
    logic [DATA_WIDTH-1:0] acc  [FLUX];
    logic [TAG_WIDTH-1:0]  last;
    logic [TAG_WIDTH-1:0]  sel;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sum;

    assign in_tag  = in_port_datain[TAG_MSB:TAG_LSB];
    assign in_data = in_port_datain[DATA_MSB:0];

    // Tags with no matching stream select nothing, so they are dropped.
    always_comb begin
        push_sel = '0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            if (in_port_write && (in_tag == TAG_WIDTH'(f))) begin
                push_sel[f] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < FLUX; g++) begin : g_fifo
        sdf_ms_fifo #(
            .DW    (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_sel[g]),
            .din   (in_data),
            .pop   (pop_sel[g]),
            .dout  (head[g]),
            .full  (in_port_full[g]),
            .empty (fifo_empty[g])
        );
    end

    // Search starts one past the last-served stream, giving round-robin order.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        sel_valid = 1'b0;
        sel       = '0;
        for (int unsigned i = 1; i <= FLUX; i++) begin
            cand = (32'(last) + i) % FLUX;
            if (!sel_valid && !fifo_empty[cand]) begin
                sel_valid = 1'b1;
                sel       = TAG_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        pop_sel = '0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            pop_sel[f] = sel_valid && !out_port_full && (sel == TAG_WIDTH'(f));
        end
    end

    assign sum = acc[sel] + head[sel];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned f = 0; f < FLUX; f++) begin
                acc[f] <= '0;
            end
            last             <= TAG_WIDTH'(FLUX - 1);
            out_port_write   <= 1'b0;
            out_port_dataout <= '0;
        end else if (sel_valid && !out_port_full) begin
            acc[sel]         <= sum;
            last             <= sel;
            out_port_write   <= 1'b1;
            out_port_dataout <= {sel, sum};
        end else begin
            out_port_write   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdf_1p_2f_ms_wrap.sv
// Directed bench for sdf_1p_2f_ms_wrap with a scoreboard queue of expected tagged sums.
module tb_sdf_1p_2f_ms_wrap;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_port_write = 1'b0;
    logic [8:0] in_port_datain = '0;
    logic [1:0] in_port_full;
    logic       out_port_write;
    logic [8:0] out_port_dataout;
    logic       out_port_full = 1'b0;

    typedef struct {
        logic [8:0] tok;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] macc [2];
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    sdf_1p_2f_ms_wrap dut (
        .clk              (clk),
        .rst              (rst),
        .in_port_write    (in_port_write),
        .in_port_datain   (in_port_datain),
        .in_port_full     (in_port_full),
        .out_port_write   (out_port_write),
        .out_port_dataout (out_port_dataout),
        .out_port_full    (out_port_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output latency is only pinned down for tokens pushed without backpressure.
    task automatic push(input logic [8:0] tok, input bit accept);
        logic t;
        @(negedge clk);
        in_port_write  = 1'b1;
        in_port_datain = tok;
        if (accept) begin
            t = tok[8];
            macc[t] = macc[t] + tok[7:0];
            exp_q.push_back('{tok: {t, macc[t]}, due: (out_port_full ? -1 : cyc + 2)});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_port_write  = 1'b0;
        in_port_datain = '0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst           = 1'b0;
        in_port_write = 1'b0;
        out_port_full = 1'b0;
        macc[0] = '0;
        macc[1] = '0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check({tag, "_write"}, out_port_write, 0);
        check({tag, "_dataout"}, out_port_dataout, 0);
        check({tag, "_in_full"}, in_port_full, 0);
        rst = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst && out_port_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", out_port_write, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", out_port_dataout, e.tok);
                if (e.due >= 0) check("out_latency", cyc, e.due);
            end
        end
    end

    initial begin
        do_reset("reset");

        // Interleaved streams, one result a cycle after each push
        push(9'h005, 1'b1);
        push(9'h10A, 1'b1);
        push(9'h003, 1'b1);
        push(9'h101, 1'b1);
        idle();
        drain("interleave_drain");

        // Accumulator wrap-around
        do_reset("reset_wrap");
        push(9'h0F0, 1'b1);
        push(9'h020, 1'b1);
        idle();
        drain("wrap_drain");

        // Backpressure fills stream 1; fifth push is dropped
        do_reset("reset_bp");
        @(negedge clk);
        out_port_full = 1'b1;
        push(9'h111, 1'b1);
        push(9'h122, 1'b1);
        push(9'h133, 1'b1);
        push(9'h144, 1'b1);
        push(9'h155, 1'b0);
        idle();
        check("bp_in_full", in_port_full, 2'b10);
        repeat (2) @(negedge clk);
        check("bp_queued", exp_q.size(), 4);
        out_port_full = 1'b0;
        drain("bp_drain");
        check("bp_in_full_after", in_port_full, 2'b00);

        // Fairness: both streams preloaded, release alternates 0,1,0,1
        do_reset("reset_fair");
        @(negedge clk);
        out_port_full = 1'b1;
        push(9'h001, 1'b1);
        push(9'h102, 1'b1);
        push(9'h003, 1'b1);
        push(9'h104, 1'b1);
        idle();
        check("fair_in_full", in_port_full, 2'b00);
        @(negedge clk);
        out_port_full = 1'b0;
        drain("fair_drain");

        // Mid-run reset discards queued tokens
        @(negedge clk);
        out_port_full = 1'b1;
        push(9'h009, 1'b0);
        push(9'h105, 1'b0);
        idle();
        do_reset("reset_mid");
        push(9'h007, 1'b1);
        idle();
        drain("mid_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
